// File: rtl/mips_fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect/halt control
// and the {pc, inst} stream to decode. master = fetch queue, slave = memory/core side.
interface mips_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_pred;
  logic              busy;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc, halt,
    output out_valid, out_pc, out_inst, out_pred, busy,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc, halt,
    input  out_valid, out_pc, out_inst, out_pred, busy,
    output out_ready
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch queue: credit-limited in-order fetch, DEPTH-entry {pc, inst} buffer,
// redirect/halt handling. Optional J/JAL predecode redirect under MIPS_FETCH_JUMP_PREDECODE_EN.
module mips_fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  mips_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  cnt_t              outst_q, outst_d;
  cnt_t              drop_q, drop_d;
  cnt_t              count_q, count_d;
  ptr_t              head_q, head_d;
  ptr_t              tail_q, tail_d;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [CNT_W:0] credit;
  logic           issue, grant, accept, pop, out_valid;

  // Credits cover both queued words and words still in flight, so a grant can never overflow.
  assign credit    = {1'b0, count_q} + {1'b0, outst_q};
  assign issue     = rst_b & ~bus.halt & ~bus.redirect_valid & (credit < (CNT_W+1)'(DEPTH));
  assign grant     = issue & bus.imem_gnt;
  assign accept    = bus.imem_rvalid & (drop_q == '0) & ~bus.redirect_valid;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & bus.out_ready;

`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
  logic              pred_pend_q, pred_pend_d;
  logic              pred_mem [DEPTH];
  logic              is_jump;
  logic [ADDR_W-1:0] jump_target;

  assign is_jump     = (bus.imem_rdata[31:26] == 6'h02) || (bus.imem_rdata[31:26] == 6'h03);
  assign jump_target = ((resp_pc_q + ADDR_W'(4)) & ~ADDR_W'(32'h0FFF_FFFF))
                     | ADDR_W'({bus.imem_rdata[25:0], 2'b00});
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    outst_d    = outst_q + cnt_t'(grant) - cnt_t'(bus.imem_rvalid);
    count_d    = count_q + cnt_t'(accept) - cnt_t'(pop);
`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
    pred_pend_d = pred_pend_q;
`endif

    if (grant)                              fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (bus.imem_rvalid && drop_q != '0)    drop_d     = drop_q - cnt_t'(1);
    if (pop)                                head_d     = head_q + ptr_t'(1);
    if (accept) begin
      tail_d    = tail_q + ptr_t'(1);
      resp_pc_d = resp_pc_q + ADDR_W'(4);
    end

`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
    if (accept) begin
      pred_pend_d = 1'b0;
      if (is_jump) begin
        fetch_pc_d  = jump_target;
        resp_pc_d   = jump_target;
        drop_d      = outst_d;
        pred_pend_d = 1'b1;
      end
    end
`endif

    // External redirect overrides everything, including a same-cycle predecoded jump.
    if (bus.redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      drop_d     = outst_d;
`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
      pred_pend_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
      pred_pend_q <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
      pred_pend_q <= pred_pend_d;
`endif
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[tail_q]   <= resp_pc_q;
      inst_mem[tail_q] <= bus.imem_rdata;
`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
      pred_mem[tail_q] <= pred_pend_q;
`endif
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? pc_mem[head_q]   : '0;
  assign bus.out_inst  = out_valid ? inst_mem[head_q] : '0;
  assign bus.busy      = (outst_q != '0) | out_valid;
`ifdef MIPS_FETCH_JUMP_PREDECODE_EN
  assign bus.out_pred  = out_valid & pred_mem[head_q];
`else
  assign bus.out_pred  = 1'b0;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_b)
    accept |-> ((count_q < cnt_t'(DEPTH)) || pop));
  a_redirect_aligned: assert property (@(posedge clk) disable iff (!rst_b)
    bus.redirect_valid |-> (bus.redirect_pc[1:0] == 2'b00));
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_b)
    bus.imem_rvalid |-> (outst_q != '0));
endmodule
